// File: rtl/core_trace_monitor.sv
// Run monitor beside the core: cycle/retire counters, ecall/ebreak/hang/timeout detection, optional trace buffer.
// Define CORE_TRACE_MONITOR_TRACE_EN to build the circular (pc, insn) trace buffer; otherwise trace outputs read 0.
module core_trace_monitor #(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 32,
  parameter int TRACE_DEPTH    = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HANG_REPEAT    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           retire,
  input  logic [XLEN-1:0]                pc,
  input  logic [31:0]                    idata,
  input  logic [XLEN-1:0]                exit_code,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]                rd_pc,
  output logic [31:0]                    rd_insn,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instret_count,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [1:0]                     cause
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int RW = $clog2(HANG_REPEAT + 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  logic [1:0]      state;
  logic [XLEN-1:0] prev_pc;
  logic [RW-1:0]   rep_cnt;
  logic            running;
  logic            is_ecall;
  logic            is_ebreak;
  logic            same_pc;
  logic            is_hang;
  logic            halt_evt;
  logic            tmo_evt;

  assign running   = (state == ST_RUN);
  assign is_ecall  = (idata == INSN_ECALL);
  assign is_ebreak = (idata == INSN_EBREAK);
  // rep_cnt == 0 means no PC retired yet, so a first PC of 0 never matches the reset value of prev_pc.
  assign same_pc   = (rep_cnt != '0) && (pc == prev_pc);
  assign is_hang   = same_pc && (rep_cnt == RW'(HANG_REPEAT - 1));
  assign halt_evt  = running && retire && (is_ecall || is_ebreak || is_hang);
  assign tmo_evt   = running && !halt_evt && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  assign done    = (state != ST_RUN);
  assign timeout = (state == ST_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_RUN;
      cycle_count   <= '0;
      instret_count <= '0;
      prev_pc       <= '0;
      rep_cnt       <= '0;
      pass          <= 1'b0;
      cause         <= 2'd0;
    end else if (running) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (retire) begin
        if (instret_count != '1) instret_count <= instret_count + 1'b1;
        prev_pc <= pc;
        rep_cnt <= same_pc ? rep_cnt + 1'b1 : RW'(1);
      end
      if (halt_evt) begin
        state <= ST_HALTED;
        if (is_ecall) begin
          cause <= 2'd1;
          pass  <= (exit_code == '0);
        end else if (is_ebreak) begin
          cause <= 2'd2;
        end else begin
          cause <= 2'd3;
        end
      end else if (tmo_evt) begin
        state <= ST_TIMEOUT;
      end
    end
  end

`ifdef CORE_TRACE_MONITOR_TRACE_EN
  logic [XLEN-1:0] mem_pc   [TRACE_DEPTH];
  logic [31:0]     mem_insn [TRACE_DEPTH];
  logic [AW-1:0]   wptr;
  logic            wr_en;

  assign wr_en = reset && running && retire;

  // Storage is deliberately not reset; trace_count masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wptr]   <= pc;
      mem_insn[wptr] <= idata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      trace_count <= '0;
      rd_pc       <= '0;
      rd_insn     <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
        if (trace_count != (AW + 1)'(TRACE_DEPTH)) trace_count <= trace_count + 1'b1;
      end
      // Reads see the pre-write pointer and memory, i.e. the view before this edge's retire.
      if ({1'b0, rd_idx} >= trace_count) begin
        rd_pc   <= '0;
        rd_insn <= '0;
      end else begin
        rd_pc   <= mem_pc[wptr - AW'(1) - rd_idx];
        rd_insn <= mem_insn[wptr - AW'(1) - rd_idx];
      end
    end
  end
`else
  logic unused_rd_idx;

  assign unused_rd_idx = ^rd_idx;
  assign rd_pc         = '0;
  assign rd_insn       = '0;
  assign trace_count   = '0;
`endif

endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed bench for core_trace_monitor (TRACE_DEPTH 4, TIMEOUT_CYCLES 50, HANG_REPEAT 4).
// Trace expectations follow whether CORE_TRACE_MONITOR_TRACE_EN is defined for the build.
module tb_core_trace_monitor;

`ifdef CORE_TRACE_MONITOR_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] idata = '0;
  logic [31:0] exit_code = '0;
  logic [1:0]  rd_idx = '0;
  logic [31:0] rd_pc;
  logic [31:0] rd_insn;
  logic [2:0]  trace_count;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  core_trace_monitor #(
    .XLEN(32), .CNT_W(32), .TRACE_DEPTH(4), .TIMEOUT_CYCLES(50), .HANG_REPEAT(4)
  ) dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .idata(idata),
    .exit_code(exit_code), .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_insn(rd_insn),
    .trace_count(trace_count), .cycle_count(cycle_count), .instret_count(instret_count),
    .done(done), .pass(pass), .timeout(timeout), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tr(input logic [63:0] v);
    return TRACE_ON ? v : 64'd0;
  endfunction

  // Drive one cycle's inputs at a falling edge; returns at the next falling edge.
  task automatic tick(input logic r, input logic [31:0] p, input logic [31:0] i);
    retire = r;
    pc     = p;
    idata  = i;
    @(posedge clk);
    @(negedge clk);
    retire = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state, sampled while reset is held
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_cycle", cycle_count, 0);
    check("rst_cause", cause, 0);
    check("rst_tcount", trace_count, 0);
    do_reset();

    // Ecall pass after three ordinary instructions
    exit_code = 32'h0;
    rd_idx    = 2'd0;
    tick(1'b1, 32'h0, 32'h13);
    tick(1'b1, 32'h4, 32'h13);
    tick(1'b1, 32'h8, 32'h13);
    check("pre_ecall_done", done, 0);
    tick(1'b1, 32'hC, 32'h73);
    check("ecall_done", done, 1);
    check("ecall_pass", pass, 1);
    check("ecall_cause", cause, 1);
    check("ecall_instret", instret_count, 4);
    check("ecall_cycle", cycle_count, 4);
    check("ecall_timeout", timeout, 0);
    check("ecall_rd_prewrite", rd_pc, tr(64'h8));
    idle(1);
    check("ecall_rd_pc", rd_pc, tr(64'hC));
    check("ecall_rd_insn", rd_insn, tr(64'h73));
    check("ecall_frozen_cycle", cycle_count, 4);

    // Ecall with nonzero exit code
    do_reset();
    exit_code = 32'h3;
    tick(1'b1, 32'h0, 32'h73);
    check("ecall3_done", done, 1);
    check("ecall3_pass", pass, 0);
    check("ecall3_cause", cause, 1);
    exit_code = 32'h0;

    // Ebreak, then retires ignored, then async reset out of HALTED
    do_reset();
    tick(1'b1, 32'h40, 32'h0010_0073);
    check("ebreak_cause", cause, 2);
    check("ebreak_pass", pass, 0);
    tick(1'b1, 32'h44, 32'h13);
    check("halted_instret", instret_count, 1);
    #1 reset = 1'b0;
    #1;
    check("halt_rst_done", done, 0);
    check("halt_rst_cause", cause, 0);
    @(negedge clk);
    reset = 1'b1;

    // Hang: same PC four times with idle cycles between
    tick(1'b1, 32'h100, 32'h6f); idle(1);
    tick(1'b1, 32'h100, 32'h6f); idle(1);
    tick(1'b1, 32'h100, 32'h6f); idle(1);
    check("hang3_done", done, 0);
    tick(1'b1, 32'h100, 32'h6f);
    check("hang_done", done, 1);
    check("hang_cause", cause, 3);
    check("hang_pass", pass, 0);
    check("hang_instret", instret_count, 4);
    check("hang_cycle", cycle_count, 7);

    // Three repeats then a new PC: no halt
    do_reset();
    tick(1'b1, 32'h100, 32'h6f);
    tick(1'b1, 32'h100, 32'h6f);
    tick(1'b1, 32'h100, 32'h6f);
    tick(1'b1, 32'h104, 32'h6f);
    tick(1'b1, 32'h104, 32'h6f);
    check("nohang_done", done, 0);
    check("nohang_instret", instret_count, 5);

    // Timeout with no retires
    do_reset();
    idle(49);
    check("tmo49_done", done, 0);
    check("tmo49_cycle", cycle_count, 49);
    idle(1);
    check("tmo_timeout", timeout, 1);
    check("tmo_done", done, 1);
    check("tmo_cycle", cycle_count, 50);
    check("tmo_cause", cause, 0);
    check("tmo_pass", pass, 0);
    idle(1);
    check("tmo_frozen", cycle_count, 50);

    // Ecall on the timeout edge wins
    do_reset();
    idle(49);
    tick(1'b1, 32'h200, 32'h73);
    check("race_timeout", timeout, 0);
    check("race_cause", cause, 1);
    check("race_pass", pass, 1);
    check("race_cycle", cycle_count, 50);
    check("race_instret", instret_count, 1);

    // Wrap-around trace: 7 retires into 4 entries
    do_reset();
    for (int k = 0; k < 7; k++) tick(1'b1, 32'(4 * k), 32'h13 | (32'(4 * k) << 16));
    check("wrap_tcount", trace_count, tr(4));
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k);
      idle(1);
      check($sformatf("wrap_rd_pc%0d", k), rd_pc, tr(64'(32'h18 - 32'(4 * k))));
    end
    rd_idx = 2'd0;
    idle(1);
    check("wrap_rd_insn0", rd_insn, tr(64'h0018_0013));

    // Two-entry buffer: indices at or beyond trace_count read zero
    do_reset();
    tick(1'b1, 32'h20, 32'h13);
    tick(1'b1, 32'h24, 32'h13);
    check("two_tcount", trace_count, tr(2));
    rd_idx = 2'd2; idle(1);
    check("two_rd2", rd_pc, 0);
    rd_idx = 2'd3; idle(1);
    check("two_rd3", rd_insn, 0);
    rd_idx = 2'd1; idle(1);
    check("two_rd1", rd_pc, tr(64'h20));
    rd_idx = 2'd0;

    // Asynchronous reset mid-run, then counting restarts from 1
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b1, 32'h1000 + 32'(4 * k), 32'h13);
    check("mid_instret", instret_count, 20);
    idle(1);
    check("mid_rd_pc", rd_pc, tr(64'h104C));
    #1 reset = 1'b0;
    #1;
    check("mid_rst_cycle", cycle_count, 0);
    check("mid_rst_instret", instret_count, 0);
    check("mid_rst_tcount", trace_count, 0);
    check("mid_rst_rd_pc", rd_pc, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, 32'h500, 32'h13);
    check("resume_cycle", cycle_count, 1);
    check("resume_instret", instret_count, 1);
    check("resume_tcount", trace_count, tr(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
